// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, sequencer state type and helpers for the ALU command sequencer.
package alu_seq_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned COUNT_W  = 16;

    localparam logic [OPCODE_W-1:0] OP_ADD     = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_SUB     = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_MUL     = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_AND     = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_OR      = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_NAND    = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_NOR     = 4'd6;
    localparam logic [OPCODE_W-1:0] OP_XOR     = 4'd7;
    localparam logic [OPCODE_W-1:0] OP_IN      = 4'd8;
    localparam logic [OPCODE_W-1:0] OP_RE      = 4'd9;
    localparam logic [OPCODE_W-1:0] OP_NOT     = 4'd10;
    localparam logic [OPCODE_W-1:0] OP_SL      = 4'd11;
    localparam logic [OPCODE_W-1:0] OP_SR      = 4'd12;
    localparam logic [OPCODE_W-1:0] OP_RSV_MIN = 4'd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_e;

    function automatic logic is_reserved(input logic [OPCODE_W-1:0] op);
        return op >= OP_RSV_MIN;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response valid/ready channels of the ALU command sequencer.
interface alu_cmd_sequencer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
);
    logic                               cmd_valid;
    logic                               cmd_ready;
    logic [alu_seq_pkg::OPCODE_W-1:0]   cmd_opcode;
    logic [WIDTH-1:0]                   cmd_a;
    logic [WIDTH-1:0]                   cmd_b;
    logic                               cmd_chain;
    logic [TAG_W-1:0]                   cmd_tag;

    logic                               rsp_valid;
    logic                               rsp_ready;
    logic [WIDTH-1:0]                   rsp_result;
    logic                               rsp_flagC;
    logic                               rsp_flagZ;
    logic                               rsp_err;
    logic [TAG_W-1:0]                   rsp_tag;

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_chain, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_flagC, rsp_flagZ, rsp_err, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_chain, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_flagC, rsp_flagZ, rsp_err, rsp_tag
    );
endinterface

// File: rtl/alu32bit.sv
// Combinational ALU: flagC is carry/borrow for arithmetic, shifted-out bit for shifts,
// nonzero high half for MUL; IN/RE are increment/decrement of A; reserved opcodes yield 0.
module alu32bit
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [WIDTH-1:0]    result,
    output logic                flagC,
    output logic                flagZ
);
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     wide;

    always_comb begin
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        wide = '0;
        case (opcode)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_MUL:  wide = {|prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0]};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_NAND: wide = {1'b0, ~(a & b)};
            OP_NOR:  wide = {1'b0, ~(a | b)};
            OP_XOR:  wide = {1'b0, a ^ b};
            OP_IN:   wide = {1'b0, a} + (WIDTH+1)'(1);
            OP_RE:   wide = {1'b0, a} - (WIDTH+1)'(1);
            OP_NOT:  wide = {1'b0, ~a};
            OP_SL:   wide = {a, 1'b0};
            OP_SR:   wide = {a[0], 1'b0, a[WIDTH-1:1]};
            default: wide = '0;
        endcase
        result = wide[WIDTH-1:0];
        flagC  = wide[WIDTH];
        flagZ  = (wide[WIDTH-1:0] == '0);
    end
endmodule

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; wrap-bit pointers, ready_o is a registered "not full".
module alu_cmd_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          empty_o,
    output logic          ready_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ready_q, full_d;
    logic          do_push, do_pop;

    assign do_push = push_i && ready_q;
    assign do_pop  = pop_i && !empty_o;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign ready_o = ready_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // Ready follows the next-state pointers so it is low in reset and never raised combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= !full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time to alu32bit and returns registered
// responses; an accumulator lets a command take the previous result as operand A.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned TAG_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.slave   bus,
    output logic                 busy,
    output logic [COUNT_W-1:0]   op_count
);
    localparam int unsigned ENTRY_W = 1 + OPCODE_W + TAG_W + 2 * WIDTH;

    logic [ENTRY_W-1:0]  fifo_wdata, fifo_rdata;
    logic                fifo_empty, fifo_ready;
    logic                push_c, pop_c;

    logic                f_chain;
    logic [OPCODE_W-1:0] f_opcode;
    logic [TAG_W-1:0]    f_tag;
    logic [WIDTH-1:0]    f_a, f_b;

    seq_state_e          state_q;
    logic [WIDTH-1:0]    op_a_q, op_b_q, acc_q;
    logic [OPCODE_W-1:0] op_code_q;
    logic [TAG_W-1:0]    op_tag_q;

    logic                rsp_valid_q, rsp_c_q, rsp_z_q, rsp_err_q;
    logic [WIDTH-1:0]    rsp_result_q;
    logic [TAG_W-1:0]    rsp_tag_q;
    logic [COUNT_W-1:0]  op_count_q;

    logic [WIDTH-1:0]    alu_result;
    logic                alu_c, alu_z;

    assign fifo_wdata = {bus.cmd_chain, bus.cmd_opcode, bus.cmd_tag, bus.cmd_a, bus.cmd_b};
    assign {f_chain, f_opcode, f_tag, f_a, f_b} = fifo_rdata;
    assign push_c = bus.cmd_valid && fifo_ready;
    // Pop from IDLE, or straight out of RESP when the response is taken (back-to-back issue).
    assign pop_c  = !fifo_empty && ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready));

    alu_cmd_fifo #(
        .DW    (ENTRY_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .ready_o (fifo_ready)
    );

    alu32bit #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (op_a_q),
        .b      (op_b_q),
        .opcode (op_code_q),
        .result (alu_result),
        .flagC  (alu_c),
        .flagZ  (alu_z)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_code_q    <= '0;
            op_tag_q     <= '0;
            acc_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_c_q      <= 1'b0;
            rsp_z_q      <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_tag_q    <= '0;
            op_count_q   <= '0;
        end else begin
            if (pop_c) begin
                op_a_q    <= f_chain ? acc_q : f_a;
                op_b_q    <= f_b;
                op_code_q <= f_opcode;
                op_tag_q  <= f_tag;
            end
            case (state_q)
                IDLE: begin
                    if (pop_c) state_q <= EXEC;
                end
                EXEC: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_result_q <= alu_result;
                    rsp_c_q      <= alu_c;
                    rsp_z_q      <= alu_z;
                    rsp_err_q    <= is_reserved(op_code_q);
                    rsp_tag_q    <= op_tag_q;
                    acc_q        <= alu_result;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + COUNT_W'(1);
                        state_q     <= pop_c ? EXEC : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = fifo_ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flagC  = rsp_c_q;
    assign bus.rsp_flagZ  = rsp_z_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign busy           = (state_q != IDLE) || !fifo_empty;
    assign op_count       = op_count_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: vector table plus hand-written latency, chaining,
// backpressure, reset and counter-wrap sequences.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] op_count;
    int          checks;
    int          errors;
    int          exp_ops;
    int          cyc;
    int          last_rsp_cyc;

    alu_cmd_sequencer_if #(.WIDTH(32), .TAG_W(4)) bus ();

    alu_cmd_sequencer #(
        .WIDTH     (32),
        .CMD_DEPTH (4),
        .TAG_W     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        chain;
        logic [3:0]  tag;
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        err;
    } vec_t;

    vec_t vecs[15];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts and ends on a falling edge; waits (bounded) for cmd_ready before the transfer edge.
    task automatic send_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic chain, input logic [3:0] tag);
        int n;
        n = 0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        bus.cmd_chain  = chain;
        bus.cmd_tag    = tag;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            bus.cmd_valid = 1'b0;
            checks++;
            errors++;
            $display("FAIL send tag %0d: cmd_ready stayed 0, expected 1", tag);
        end else begin
            @(posedge clk);
            @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
    endtask

    // Raises rsp_ready, waits (bounded) for a response and compares it; leaves rsp_ready high.
    task automatic collect_rsp(input string name, input logic [31:0] res, input logic c,
                               input logic z, input logic err, input logic [3:0] tag);
        int n;
        n = 0;
        bus.rsp_ready = 1'b1;
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: rsp_valid=0, expected 1", name);
        end else begin
            last_rsp_cyc = cyc;
            check({name, " result"}, bus.rsp_result, res);
            check({name, " flagC"}, 32'(bus.rsp_flagC), 32'(c));
            check({name, " flagZ"}, 32'(bus.rsp_flagZ), 32'(z));
            check({name, " err"}, 32'(bus.rsp_err), 32'(err));
            check({name, " tag"}, 32'(bus.rsp_tag), 32'(tag));
            exp_ops++;
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0]  = '{OP_ADD,  32'd100,        32'd50,         1'b0, 4'd1,  32'd150,        1'b0, 1'b0, 1'b0};
        vecs[1]  = '{OP_SUB,  32'd5,          32'd7,          1'b0, 4'd2,  32'hFFFF_FFFE,  1'b1, 1'b0, 1'b0};
        vecs[2]  = '{OP_MUL,  32'h0001_0000,  32'h0001_0000,  1'b0, 4'd3,  32'h0,          1'b1, 1'b1, 1'b0};
        vecs[3]  = '{OP_AND,  32'h0000_F0F0,  32'h0000_FF00,  1'b0, 4'd4,  32'h0000_F000,  1'b0, 1'b0, 1'b0};
        vecs[4]  = '{OP_OR,   32'h0,          32'h0,          1'b0, 4'd5,  32'h0,          1'b0, 1'b1, 1'b0};
        vecs[5]  = '{OP_NAND, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 4'd6,  32'h0,          1'b0, 1'b1, 1'b0};
        vecs[6]  = '{OP_NOR,  32'h0,          32'h0,          1'b0, 4'd7,  32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0};
        vecs[7]  = '{OP_XOR,  32'hAAAA_5555,  32'hFFFF_0000,  1'b0, 4'd8,  32'h5555_5555,  1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_IN,   32'hFFFF_FFFF,  32'h0,          1'b0, 4'd9,  32'h0,          1'b1, 1'b1, 1'b0};
        vecs[9]  = '{OP_RE,   32'h0,          32'h0,          1'b0, 4'd10, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0};
        vecs[10] = '{OP_NOT,  32'h0000_FFFF,  32'h0,          1'b0, 4'd11, 32'hFFFF_0000,  1'b0, 1'b0, 1'b0};
        vecs[11] = '{OP_SL,   32'h8000_0001,  32'h0,          1'b0, 4'd12, 32'h0000_0002,  1'b1, 1'b0, 1'b0};
        vecs[12] = '{OP_SR,   32'h0000_0003,  32'h0,          1'b0, 4'd13, 32'h0000_0001,  1'b1, 1'b0, 1'b0};
        vecs[13] = '{OP_ADD,  32'd999,        32'd1,          1'b1, 4'd14, 32'd2,          1'b0, 1'b0, 1'b0};
        vecs[14] = '{4'b1110, 32'd1,          32'd2,          1'b0, 4'd15, 32'h0,          1'b0, 1'b1, 1'b1};

        checks = 0; errors = 0; exp_ops = 0; cyc = 0; last_rsp_cyc = 0;
        clk = 1'b0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.cmd_chain = 1'b0; bus.cmd_tag = '0; bus.rsp_ready = 1'b0;

        // Reset state
        #1;
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset op_count", 32'(op_count), 32'd0);
        check("reset rsp_result", bus.rsp_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready after reset", 32'(bus.cmd_ready), 32'd1);

        // Latency: accepted at edge N, rsp_valid at edge N+2
        send_cmd(OP_ADD, 32'd100, 32'd50, 1'b0, 4'd1);
        check("lat N rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("lat N busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat N+1 rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check("lat N+2 rsp_valid", 32'(bus.rsp_valid), 32'd1);
        collect_rsp("lat add", 32'd150, 1'b0, 1'b0, 1'b0, 4'd1);

        // Opcode table
        for (int i = 0; i < 15; i++) begin
            send_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].chain, vecs[i].tag);
            collect_rsp($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].z,
                        vecs[i].err, vecs[i].tag);
        end
        check("op_count after table", 32'(op_count), 32'(exp_ops));

        // Back-to-back SUB then chained SUB, rsp_ready held high
        begin
            int t1;
            bus.rsp_ready = 1'b1;
            send_cmd(OP_SUB, 32'd100, 32'd50, 1'b0, 4'd3);
            send_cmd(OP_SUB, 32'd7, 32'd50, 1'b1, 4'd4);
            collect_rsp("b2b sub", 32'd50, 1'b0, 1'b0, 1'b0, 4'd3);
            t1 = last_rsp_cyc;
            collect_rsp("b2b chained", 32'd0, 1'b0, 1'b1, 1'b0, 4'd4);
            check("b2b spacing", 32'(last_rsp_cyc - t1), 32'd2);
        end

        // Backpressure: 1 executing + 4 buffered, then cmd_ready drops
        bus.rsp_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_cmd(OP_ADD, 32'(i), 32'd10, 1'b0, 4'(i));
        check("full cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("full busy", 32'(busy), 32'd1);
        bus.cmd_valid = 1'b1; bus.cmd_opcode = OP_ADD; bus.cmd_a = 32'd6; bus.cmd_b = 32'd10;
        bus.cmd_chain = 1'b0; bus.cmd_tag = 4'd6;
        @(negedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("hold rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("hold rsp_result", bus.rsp_result, 32'd11);
        check("hold rsp_tag", 32'(bus.rsp_tag), 32'd1);
        bus.rsp_ready = 1'b1;
        check("pop while full cmd_ready", 32'(bus.cmd_ready), 32'd0);
        collect_rsp("bp1", 32'd11, 1'b0, 1'b0, 1'b0, 4'd1);
        check("cmd_ready after pop", 32'(bus.cmd_ready), 32'd1);
        for (int i = 2; i <= 5; i++)
            collect_rsp($sformatf("bp%0d", i), 32'(i + 10), 1'b0, 1'b0, 1'b0, 4'(i));
        repeat (4) @(negedge clk);
        check("drained rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("drained busy", 32'(busy), 32'd0);
        check("drained op_count", 32'(op_count), 32'(exp_ops));

        // Reset during EXEC with one more command buffered
        bus.rsp_ready = 1'b0;
        send_cmd(OP_ADD, 32'd7, 32'd8, 1'b0, 4'd7);
        send_cmd(OP_ADD, 32'd9, 32'd9, 1'b0, 4'd8);
        rst = 1'b1;
        #1;
        check("mid rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst acc", dut.acc_q, 32'd0);
        check("mid rst op_count", 32'(op_count), 32'd0);
        exp_ops = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("post rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("post rst no rsp", 32'(bus.rsp_valid), 32'd0);
        check("post rst busy", 32'(busy), 32'd0);
        send_cmd(OP_ADD, 32'd123, 32'd5, 1'b1, 4'd9);
        collect_rsp("post rst chain", 32'd5, 1'b0, 1'b0, 1'b0, 4'd9);
        send_cmd(OP_ADD, 32'd1, 32'd2, 1'b0, 4'd10);
        collect_rsp("post rst add", 32'd3, 1'b0, 1'b0, 1'b0, 4'd10);

        // op_count wrap
        force dut.op_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_q;
        @(negedge clk);
        check("op_count preset", 32'(op_count), 32'h0000_FFFF);
        send_cmd(OP_ADD, 32'd0, 32'd0, 1'b0, 4'd11);
        collect_rsp("wrap add", 32'd0, 1'b0, 1'b1, 1'b0, 4'd11);
        check("op_count wrap", 32'(op_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
